nd_1to2: RTL and testbench

//  One-input, two-output message router node: the stage between a channel source and two channel sinks.
//  - Accepts one message per four-phase req/ack handshake on input channel i0.
//  - Verifies the message's redundancy field.
//  - Forwards the message to o0 when the destination compare is true, else to o1.
//  - Each output holds a one-entry buffer, so the input can accept a new message while the other output is busy.

---
 rtl/nd_1to2_pkg.sv | 25 ++
 rtl/nd_out_port.sv | 74 +++++++
 rtl/nd_1to2.sv | 120 ++++++++++++
 tb/tb_nd_1to2.sv | 136 +++++++++++++
 4 files changed

// File: rtl/nd_1to2_pkg.sv
// nd_1to2_pkg: shared constants, compare operators, state encodings and redundancy helper for the router node
package nd_1to2_pkg;
  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE = 8;
  localparam int NS_REDUN_SIZE = 4;
  localparam bit NS_TRUE = 1'b1;
  localparam bit NS_FALSE = 1'b0;
  typedef enum logic [2:0] {NS_GT_OP, NS_GE_OP, NS_LT_OP, NS_LE_OP, NS_EQ_OP, NS_NE_OP} ns_op_e;
  typedef enum logic [2:0] {IN_IDLE, IN_CAPT, IN_CHK, IN_ROUTE, IN_ACKW} in_state_e;
  typedef enum logic [1:0] {OUT_EMPTY, OUT_REQ, OUT_WAITLO} out_state_e;
  function automatic logic [31:0] calc_redun(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] dat);
    return src + dst + dat;
  endfunction
  function automatic logic ns_cmp(input ns_op_e op, input logic [31:0] a, input logic [31:0] b);
    return op == NS_GT_OP ? a > b :
           op == NS_GE_OP ? a >= b :
           op == NS_LT_OP ? a < b :
           op == NS_LE_OP ? a <= b :
           op == NS_EQ_OP ? a == b : a != b;
  endfunction
  function automatic logic ns_range_cmp(input ns_op_e op1, input logic [31:0] r1, input bit rng,
                                        input ns_op_e op2, input logic [31:0] r2, input logic [31:0] v);
    return ns_cmp(op1, v, r1) && (!rng || ns_cmp(op2, v, r2));
  endfunction
endpackage

// File: rtl/nd_out_port.sv
// nd_out_port: one-entry output buffer with four-phase req/ack FSM, ack synchroniser, proto-error flag and delivery counter
//   wr_i/src_i/dst_i/dat_i/red_i: buffer write; rdy_o: buffer may be written this cycle
//   src_o/dst_o/dat_o/red_o/req_o/ack_i: output channel; err_o: sticky proto error; cnt_o: delivered count mod 16
module nd_out_port import nd_1to2_pkg::*; #(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_i,
  input  logic [ASZ-1:0] src_i,
  input  logic [ASZ-1:0] dst_i,
  input  logic [DSZ-1:0] dat_i,
  input  logic [RSZ-1:0] red_i,
  output logic           rdy_o,
  output logic [ASZ-1:0] src_o,
  output logic [ASZ-1:0] dst_o,
  output logic [DSZ-1:0] dat_o,
  output logic [RSZ-1:0] red_o,
  output logic           req_o,
  input  logic           ack_i,
  output logic           err_o,
  output logic [3:0]     cnt_o
);
  out_state_e st_q, st_d;
  logic [1:0] ack_q;
  logic ack_s, free, err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ASZ-1:0] src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;
  assign ack_s = ack_q[1];
  assign free = st_q == OUT_WAITLO && !ack_s;
  // a buffer freed this cycle can be refilled at once; the write wins
  always_comb begin
    st_d = wr_i ? OUT_REQ : (st_q == OUT_REQ && ack_s) ? OUT_WAITLO : free ? OUT_EMPTY : st_q;
    err_d = err_q | (st_q == OUT_EMPTY && ack_s);
    cnt_d = cnt_q + {3'b0, free};
    src_d = wr_i ? src_i : src_q;
    dst_d = wr_i ? dst_i : dst_q;
    dat_d = wr_i ? dat_i : dat_q;
    red_d = wr_i ? red_i : red_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= OUT_EMPTY;
      ack_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      dat_q <= '0;
      red_q <= '0;
    end else begin
      st_q <= st_d;
      ack_q <= {ack_q[0], ack_i};
      err_q <= err_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      dst_q <= dst_d;
      dat_q <= dat_d;
      red_q <= red_d;
    end
  end
  assign rdy_o = st_q == OUT_EMPTY || free;
  assign req_o = st_q == OUT_REQ;
  assign err_o = err_q;
  assign cnt_o = cnt_q;
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign dat_o = dat_q;
  assign red_o = red_q;
endmodule

// File: rtl/nd_1to2.sv
// nd_1to2: one-input two-output message router node with redundancy check and destination compare routing
//   i0_*: input channel (req/ack four-phase); o0_*: compare-true channel; o1_*: compare-false channel
//   dbg_leds: {0, o1 proto err, o0 proto err, redun err}; dbg_disp0/1: delivered counts mod 16
module nd_1to2 import nd_1to2_pkg::*; #(
  parameter ns_op_e OPER_1 = NS_GT_OP,
  parameter int REF_VAL_1 = 0,
  parameter bit IS_RANGE = NS_FALSE,
  parameter ns_op_e OPER_2 = NS_GT_OP,
  parameter int REF_VAL_2 = 0,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o1_src,
  output logic [ASZ-1:0] o1_dst,
  output logic [DSZ-1:0] o1_dat,
  output logic [RSZ-1:0] o1_red,
  output logic           o1_req,
  input  logic           o1_ack,
  output logic [3:0]     dbg_leds,
  output logic [3:0]     dbg_disp0,
  output logic [3:0]     dbg_disp1
);
  in_state_e st_q, st_d;
  logic [1:0] req_q;
  logic req_s, rdy0, rdy1, wr0, wr1, err0, err1;
  logic to0_q, to0_d, red_err_q, red_err_d;
  logic [ASZ-1:0] src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d, calc_q, calc_d;
  assign req_s = req_q[1];
  always_comb begin
    st_d = st_q;
    src_d = src_q;
    dst_d = dst_q;
    dat_d = dat_q;
    red_d = red_q;
    calc_d = calc_q;
    to0_d = to0_q;
    red_err_d = red_err_q;
    wr0 = 1'b0;
    wr1 = 1'b0;
    case (st_q)
      IN_IDLE: if (req_s && !i0_ack) begin
        src_d = i0_src;
        dst_d = i0_dst;
        dat_d = i0_dat;
        red_d = i0_red;
        st_d = IN_CAPT;
      end
      IN_CAPT: begin
        calc_d = RSZ'(calc_redun(32'(src_q), 32'(dst_q), 32'(dat_q)));
        st_d = IN_CHK;
      end
      IN_CHK: begin
        red_err_d = red_err_q | (calc_q != red_q);
        to0_d = ns_range_cmp(OPER_1, 32'(REF_VAL_1), IS_RANGE, OPER_2, 32'(REF_VAL_2), 32'(dst_q));
        st_d = calc_q != red_q ? IN_ACKW : IN_ROUTE;
      end
      IN_ROUTE: if (to0_q ? rdy0 : rdy1) begin
        wr0 = to0_q;
        wr1 = !to0_q;
        st_d = IN_ACKW;
      end
      IN_ACKW: st_d = req_s ? IN_ACKW : IN_IDLE;
      default: st_d = IN_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IN_IDLE;
      req_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      dat_q <= '0;
      red_q <= '0;
      calc_q <= '0;
      to0_q <= 1'b0;
      red_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      req_q <= {req_q[0], i0_req};
      src_q <= src_d;
      dst_q <= dst_d;
      dat_q <= dat_d;
      red_q <= red_d;
      calc_q <= calc_d;
      to0_q <= to0_d;
      red_err_q <= red_err_d;
    end
  end
  assign i0_ack = st_q == IN_ACKW;
  assign dbg_leds = {1'b0, err1, err0, red_err_q};
  nd_out_port #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_o0 (
    .clk(clk), .reset(reset), .wr_i(wr0),
    .src_i(src_q), .dst_i(dst_q), .dat_i(dat_q), .red_i(red_q), .rdy_o(rdy0),
    .src_o(o0_src), .dst_o(o0_dst), .dat_o(o0_dat), .red_o(o0_red),
    .req_o(o0_req), .ack_i(o0_ack), .err_o(err0), .cnt_o(dbg_disp0)
  );
  nd_out_port #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_o1 (
    .clk(clk), .reset(reset), .wr_i(wr1),
    .src_i(src_q), .dst_i(dst_q), .dat_i(dat_q), .red_i(red_q), .rdy_o(rdy1),
    .src_o(o1_src), .dst_o(o1_dst), .dat_o(o1_dat), .red_o(o1_red),
    .req_o(o1_req), .ack_i(o1_ack), .err_o(err1), .cnt_o(dbg_disp1)
  );
endmodule

// File: tb/tb_nd_1to2.sv
// tb_nd_1to2: directed self-checking bench for the nd_1to2 router node
module tb_nd_1to2;
  import nd_1to2_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] i0_src = '0, i0_dst = '0, o0_src, o0_dst, o1_src, o1_dst;
  logic [7:0] i0_dat = '0, o0_dat, o1_dat;
  logic [3:0] i0_red = '0, o0_red, o1_red, dbg_leds, dbg_disp0, dbg_disp1;
  logic i0_req = 1'b0, i0_ack, o0_req, o0_ack = 1'b0, o1_req, o1_ack = 1'b0;
  int errors = 0, checks = 0, acks = 0, a0;
  always #5 clk = ~clk;
  always @(posedge i0_ack) acks++;
  nd_1to2 #(.OPER_1(NS_GT_OP), .REF_VAL_1(1)) dut (
    .clk(clk), .reset(reset),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red), .i0_req(i0_req), .i0_ack(i0_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red), .o0_req(o0_req), .o0_ack(o0_ack),
    .o1_src(o1_src), .o1_dst(o1_dst), .o1_dat(o1_dat), .o1_red(o1_red), .o1_req(o1_req), .o1_ack(o1_ack),
    .dbg_leds(dbg_leds), .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic sig(input int w);
    return w == 0 ? i0_ack : w == 1 ? o0_req : o1_req;
  endfunction
  task automatic wait_for(input int w, input logic v, input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sig(w) == v) break;
    end
    chk(tag, 32'(sig(w)), 32'(v));
  endtask
  task automatic send_start(input logic [5:0] s, input logic [5:0] d, input logic [7:0] da, input logic [3:0] r);
    i0_src = s;
    i0_dst = d;
    i0_dat = da;
    i0_red = r;
    i0_req = 1'b1;
  endtask
  task automatic send_end(input string tag);
    wait_for(0, 1'b1, {tag, "_ack_hi"});
    i0_req = 1'b0;
    wait_for(0, 1'b0, {tag, "_ack_lo"});
  endtask
  task automatic send(input logic [5:0] s, input logic [5:0] d, input logic [7:0] da, input logic [3:0] r, input string tag);
    send_start(s, d, da, r);
    send_end(tag);
  endtask
  task automatic recv(input int p, input logic [5:0] s, input logic [5:0] d, input logic [7:0] da, input logic [3:0] r, input string tag);
    wait_for(p, 1'b1, {tag, "_req_hi"});
    chk({tag, "_src"}, 32'(p == 1 ? o0_src : o1_src), 32'(s));
    chk({tag, "_dst"}, 32'(p == 1 ? o0_dst : o1_dst), 32'(d));
    chk({tag, "_dat"}, 32'(p == 1 ? o0_dat : o1_dat), 32'(da));
    chk({tag, "_red"}, 32'(p == 1 ? o0_red : o1_red), 32'(r));
    if (p == 1) o0_ack = 1'b1; else o1_ack = 1'b1;
    wait_for(p, 1'b0, {tag, "_req_lo"});
    if (p == 1) o0_ack = 1'b0; else o1_ack = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_i0_ack", 32'(i0_ack), 0);
    chk("rst_o0_req", 32'(o0_req), 0);
    chk("rst_o1_req", 32'(o1_req), 0);
    chk("rst_o0_dat", 32'(o0_dat), 0);
    chk("rst_dbg", {20'd0, dbg_leds, dbg_disp0, dbg_disp1}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(9, 2, 5, 4'h0, "s1");
    chk("s1_o1_idle", 32'(o1_req), 0);
    recv(1, 9, 2, 5, 4'h0, "s1_o0");
    chk("s1_disp0", 32'(dbg_disp0), 1);
    chk("s1_o1_still", 32'(o1_req), 0);
    a0 = acks;
    send(9, 1, 5, 4'hf, "s2");
    chk("s2_ack_once", 32'(acks - a0), 1);
    recv(2, 9, 1, 5, 4'hf, "s2_o1");
    chk("s2_disp1", 32'(dbg_disp1), 1);
    chk("s2_leds", 32'(dbg_leds), 0);
    a0 = acks;
    send(9, 2, 5, 4'h1, "s3");
    chk("s3_ack_once", 32'(acks - a0), 1);
    repeat (10) @(negedge clk);
    chk("s3_o0_req", 32'(o0_req), 0);
    chk("s3_o1_req", 32'(o1_req), 0);
    chk("s3_led0", 32'(dbg_leds), 1);
    chk("s3_disp", {24'd0, dbg_disp0, dbg_disp1}, 8'h11);
    send(3, 2, 8'h0a, 4'hf, "s4a");
    send_start(4, 2, 8'h0b, 4'h1);
    repeat (20) @(negedge clk);
    chk("s4_stall_ack", 32'(i0_ack), 0);
    chk("s4_stall_o1", 32'(o1_req), 0);
    recv(1, 3, 2, 8'h0a, 4'hf, "s4_a");
    send_end("s4b");
    send(5, 1, 8'h0c, 4'h2, "s4c");
    recv(1, 4, 2, 8'h0b, 4'h1, "s4_b");
    recv(2, 5, 1, 8'h0c, 4'h2, "s4_c");
    chk("s4_led0_sticky", 32'(dbg_leds), 1);
    chk("s4_disp", {24'd0, dbg_disp0, dbg_disp1}, 8'h32);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      send(3, 2, 8'(i), 4'(5 + i), "s5");
      recv(1, 3, 2, 8'(i), 4'(5 + i), $sformatf("s5_m%0d", i));
    end
    chk("s5_disp0_wrap", 32'(dbg_disp0), 1);
    chk("s5_disp1", 32'(dbg_disp1), 0);
    o1_ack = 1'b1;
    repeat (4) @(negedge clk);
    o1_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_led2", 32'(dbg_leds), 4);
    chk("s5_o1_req", 32'(o1_req), 0);
    send(9, 2, 5, 4'h0, "s6pre");
    chk("s6_o0_req_hi", 32'(o0_req), 1);
    #2 reset = 1'b1;
    #1;
    chk("s6_async_o0_req", 32'(o0_req), 0);
    chk("s6_async_i0_ack", 32'(i0_ack), 0);
    chk("s6_async_dbg", {20'd0, dbg_leds, dbg_disp0, dbg_disp1}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(9, 2, 5, 4'h0, "s6");
    recv(1, 9, 2, 5, 4'h0, "s6_o0");
    chk("s6_disp0", 32'(dbg_disp0), 1);
    chk("s6_o1_req", 32'(o1_req), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
